// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the FPU pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    // Integer register $zero: a load targeting it never creates a hazard.
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_VEC   = 2'd2
    } ctrl_state_e;

    // Next-PC override select codes.
    localparam logic [1:0] RSEL_NONE   = 2'b00;
    localparam logic [1:0] RSEL_BRANCH = 2'b01;
    localparam logic [1:0] RSEL_VECTOR = 2'b10;

endpackage

// File: rtl/fpu_busy_tracker.sv
// Tracks the single in-flight long FP operation (FDIV/FSQRT): a down-counter
// of remaining cycles and the destination register it will write.
module fpu_busy_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int FDIV_LAT  = 16,
    parameter int FSQRT_LAT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             sel_sqrt,
    input  logic [REG_W-1:0] id_fd,
    output logic             fpu_busy,
    output logic [REG_W-1:0] busy_fd
);

    localparam int MAX_LAT = (FDIV_LAT > FSQRT_LAT) ? FDIV_LAT : FSQRT_LAT;
    localparam int CW      = $clog2(MAX_LAT);

    // Accept cycle counts as the first latency cycle, so the counter starts at LAT-1.
    localparam logic [CW-1:0] FDIV_LOAD  = CW'(FDIV_LAT - 1);
    localparam logic [CW-1:0] FSQRT_LOAD = CW'(FSQRT_LAT - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [REG_W-1:0] busy_fd_q, busy_fd_d;

    // Load on accept, otherwise count down and stop at zero.
    always_comb begin
        cnt_d     = cnt_q;
        busy_fd_d = busy_fd_q;
        if (accept) begin
            cnt_d     = sel_sqrt ? FSQRT_LOAD : FDIV_LOAD;
            busy_fd_d = id_fd;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter and destination register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            busy_fd_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            busy_fd_q <= busy_fd_d;
        end
    end

    assign fpu_busy = (cnt_q != '0);
    assign busy_fd  = busy_fd_q;

endmodule

// File: rtl/pipe_hazard_ctrl_fpu.sv
// Central stall/flush controller for the five-stage FPU pipeline. Resolves
// load-use and long-FP-op hazards, ID branch mispredicts and interrupt entry.
module pipe_hazard_ctrl_fpu
    import pipe_ctrl_pkg::*;
#(
    parameter int FDIV_LAT  = 16,
    parameter int FSQRT_LAT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_fs,
    input  logic [REG_W-1:0] id_ft,
    input  logic [REG_W-1:0] id_fd,
    input  logic             id_use_fs,
    input  logic             id_use_ft,
    input  logic             id_fdiv,
    input  logic             id_fsqrt,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [REG_W-1:0] ex_rn,
    input  logic             id_mispredict,
    input  logic             intr,
    input  logic             ie,
    output logic             wpcir,
    output logic             ifid_flush,
    output logic             id_bubble,
    output logic             redirect,
    output logic [1:0]       redirect_sel,
    output logic             fpu_busy,
    output logic             intr_ack
);

    ctrl_state_e      state_q, state_d;
    logic             busy;
    logic [REG_W-1:0] busy_fd;
    logic             lu, fph, stall, long_accept;

    // Load in EX feeding an integer source of the ID instruction.
    assign lu = ex_m2reg & ex_wreg & (ex_rn != REG_ZERO) &
                ((id_use_rs & (id_rs == ex_rn)) | (id_use_rt & (id_rt == ex_rn)));

    // Long op in flight: block readers of its result and any second long op.
    assign fph = busy & ((id_use_fs & (id_fs == busy_fd)) |
                         (id_use_ft & (id_ft == busy_fd)) |
                         id_fdiv | id_fsqrt);

    assign stall       = lu | fph;
    assign long_accept = (id_fdiv | id_fsqrt) & ~stall & (state_q == ST_RUN);

    fpu_busy_tracker #(
        .FDIV_LAT  (FDIV_LAT),
        .FSQRT_LAT (FSQRT_LAT)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .accept   (long_accept),
        .sel_sqrt (id_fsqrt),
        .id_fd    (id_fd),
        .fpu_busy (busy),
        .busy_fd  (busy_fd)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next state: stall beats mispredict beats interrupt; DRAIN waits for the FPU.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (intr & ie & ~stall & ~id_mispredict) state_d = ST_DRAIN;
            ST_DRAIN: if (~busy) state_d = ST_VEC;
            ST_VEC:   state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Outputs from state and current hazards; everything held low during reset.
    always_comb begin
        wpcir        = 1'b0;
        ifid_flush   = 1'b0;
        id_bubble    = 1'b0;
        redirect     = 1'b0;
        redirect_sel = RSEL_NONE;
        fpu_busy     = 1'b0;
        intr_ack     = 1'b0;
        if (!rst) begin
            fpu_busy = busy;
            case (state_q)
                ST_RUN: begin
                    if (stall) begin
                        id_bubble = 1'b1;
                    end else if (id_mispredict) begin
                        wpcir        = 1'b1;
                        ifid_flush   = 1'b1;
                        redirect     = 1'b1;
                        redirect_sel = RSEL_BRANCH;
                    end else begin
                        wpcir = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    id_bubble = 1'b1;
                end
                ST_VEC: begin
                    wpcir        = 1'b1;
                    ifid_flush   = 1'b1;
                    id_bubble    = 1'b1;
                    redirect     = 1'b1;
                    redirect_sel = RSEL_VECTOR;
                    intr_ack     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
